// File: rtl/uart_tx_arb_pkg.sv
// Shared encodings and helpers for the uart_tx_arb slice.
package uart_tx_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT_HI = 2'd2,
    S_WAIT_LO = 2'd3
  } arb_state_t;

  // Cycles (counted from the start pulse) to wait for busy before assuming
  // the transmitter finished without ever raising it.
  localparam int WAIT_HI_TO = 4;

  // Requester index + 1, wrapping at n.
  function automatic int wrap_inc(input int id, input int n);
    return (id + 1 >= n) ? 0 : id + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping. The request vector is doubled so the wrap becomes a plain
// lowest-set-bit search over a masked vector.
module uart_tx_arb_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    idx,
  output logic               found
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [2*NUM_REQ-1:0] msk;
  logic [2*NUM_REQ-1:0] cand;

  // Mask off lower-half bits below ptr, then keep the lowest surviving bit.
  always_comb begin
    dbl   = {req, req};
    msk   = '0;
    idx   = '0;
    found = 1'b0;
    for (int j = 0; j < 2*NUM_REQ; j++) msk[j] = (j >= int'(ptr));
    cand = dbl & msk;
    for (int j = 2*NUM_REQ-1; j >= 0; j--) begin
      if (cand[j]) begin
        found = 1'b1;
        idx   = (j >= NUM_REQ) ? ID_W'(j - NUM_REQ) : ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin packet arbiter in front of a single uart_tx byte transmitter.
// A granted requester keeps the transmitter until its last byte; a gap
// watchdog releases a requester that stalls mid-packet.
module uart_tx_arb
  import uart_tx_arb_pkg::*;
#(
  parameter int          NUM_REQ = 4,
  parameter int          DATA_W  = 8,
  parameter logic [15:0] GAP_MAX = 16'd50000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_vld,
  input  logic [NUM_REQ*DATA_W-1:0]     req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic [DATA_W-1:0]             tx_din,
  output logic                          tx_din_vld,
  input  logic                          tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          pkt_abort
);

  localparam int          ID_W     = $clog2(NUM_REQ);
  localparam logic [15:0] GAP_LAST = GAP_MAX - 16'd1;
  localparam logic [2:0]  HI_LAST  = 3'(WAIT_HI_TO - 1);

  arb_state_t          state, state_d;
  logic                locked, locked_d;
  logic [ID_W-1:0]     rr_ptr, rr_ptr_d;
  logic [15:0]         gap_cnt, gap_d;
  logic                last_q, last_d;
  logic [2:0]          hi_cnt, hi_d;
  logic [ID_W-1:0]     gid_d;
  logic [DATA_W-1:0]   din_d;
  logic                vld_d, abort_d;
  logic [NUM_REQ-1:0]  ack_d;
  logic [ID_W-1:0]     pick_idx;
  logic                pick_found;

  uart_tx_arb_rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .req   (req_vld),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  // Next state plus next values of every registered output and counter.
  always_comb begin
    state_d  = state;
    locked_d = locked;
    rr_ptr_d = rr_ptr;
    gap_d    = gap_cnt;
    last_d   = last_q;
    hi_d     = hi_cnt;
    gid_d    = grant_id;
    din_d    = tx_din;
    abort_d  = 1'b0;
    case (state)
      S_IDLE: begin
        if (!locked) begin
          if (pick_found) begin
            gid_d    = pick_idx;
            din_d    = req_data[int'(pick_idx)*DATA_W +: DATA_W];
            last_d   = req_last[pick_idx];
            locked_d = 1'b1;
            state_d  = S_ISSUE;
          end
        end else if (gap_cnt == GAP_LAST) begin
          // Expiry beats a request arriving the same cycle; it re-arbitrates.
          abort_d  = 1'b1;
          locked_d = 1'b0;
          rr_ptr_d = ID_W'(wrap_inc(int'(grant_id), NUM_REQ));
          gap_d    = '0;
        end else if (req_vld[grant_id]) begin
          din_d   = req_data[int'(grant_id)*DATA_W +: DATA_W];
          last_d  = req_last[grant_id];
          state_d = S_ISSUE;
        end else begin
          // Bounded by the expiry branch above, so it never passes GAP_LAST.
          gap_d = gap_cnt + 16'd1;
        end
      end
      S_ISSUE: begin
        if (last_q) begin
          locked_d = 1'b0;
          rr_ptr_d = ID_W'(wrap_inc(int'(grant_id), NUM_REQ));
        end
        gap_d   = '0;
        hi_d    = 3'd1;  // the issue cycle is the first of the busy window
        state_d = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (tx_busy)                state_d = S_WAIT_LO;
        else if (hi_cnt >= HI_LAST) state_d = S_IDLE;
        else                        hi_d    = hi_cnt + 3'd1;
      end
      S_WAIT_LO: begin
        if (!tx_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    vld_d = (state_d == S_ISSUE);
    ack_d = '0;
    if (vld_d) ack_d[gid_d] = 1'b1;
  end

  // Registered datapath, counters and outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked     <= 1'b0;
      rr_ptr     <= '0;
      gap_cnt    <= '0;
      last_q     <= 1'b0;
      hi_cnt     <= '0;
      grant_id   <= '0;
      tx_din     <= '0;
      tx_din_vld <= 1'b0;
      req_ack    <= '0;
      pkt_abort  <= 1'b0;
    end else begin
      locked     <= locked_d;
      rr_ptr     <= rr_ptr_d;
      gap_cnt    <= gap_d;
      last_q     <= last_d;
      hi_cnt     <= hi_d;
      grant_id   <= gid_d;
      tx_din     <= din_d;
      tx_din_vld <= vld_d;
      req_ack    <= ack_d;
      pkt_abort  <= abort_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: requester queues, a busy-flag transmitter model and
// a scoreboard of expected (grant, byte) pairs in issue order.
module tb_uart_tx_arb;

  localparam int NR = 4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR-1:0]   req_vld = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]   req_last = '0;
  logic [NR-1:0]   req_ack;
  logic [DW-1:0]   tx_din;
  logic            tx_din_vld;
  logic            tx_busy = 1'b0;
  logic [1:0]      grant_id;
  logic            pkt_abort;

  uart_tx_arb #(.NUM_REQ(NR), .DATA_W(DW), .GAP_MAX(16'd16)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_data(req_data),
    .req_last(req_last), .req_ack(req_ack), .tx_din(tx_din),
    .tx_din_vld(tx_din_vld), .tx_busy(tx_busy), .grant_id(grant_id),
    .pkt_abort(pkt_abort)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [1:0] id; logic [7:0] data; } exp_t;

  int   cyc = 0, npass = 0, ntotal = 0;
  int   bus_d = 1, bus_l = 4, busy_start = 0, busy_end = 0;
  exp_t exp_q[$];
  int   vld_cyc[$];
  int   abort_cyc[$];
  logic [8:0] rq0[$], rq1[$], rq2[$], rq3[$];
  logic [3:0] pop_pend = '0;
  exp_t e;
  logic [3:0] oh;

  function automatic void push_req(input int i, input logic l, input logic [7:0] d);
    case (i)
      0: rq0.push_back({l, d});
      1: rq1.push_back({l, d});
      2: rq2.push_back({l, d});
      default: rq3.push_back({l, d});
    endcase
  endfunction

  function automatic void pop_req(input int i);
    case (i)
      0: if (rq0.size() != 0) void'(rq0.pop_front());
      1: if (rq1.size() != 0) void'(rq1.pop_front());
      2: if (rq2.size() != 0) void'(rq2.pop_front());
      default: if (rq3.size() != 0) void'(rq3.pop_front());
    endcase
  endfunction

  function automatic void push_exp(input int i, input logic [7:0] d);
    exp_t x;
    x.id = 2'(i);
    x.data = d;
    exp_q.push_back(x);
  endfunction

  task automatic apply_reqs();
    req_vld = {rq3.size() != 0, rq2.size() != 0, rq1.size() != 0, rq0.size() != 0};
    if (rq0.size() != 0) {req_last[0], req_data[7:0]}   = rq0[0];
    if (rq1.size() != 0) {req_last[1], req_data[15:8]}  = rq1[0];
    if (rq2.size() != 0) {req_last[2], req_data[23:16]} = rq2[0];
    if (rq3.size() != 0) {req_last[3], req_data[31:24]} = rq3[0];
  endtask

  // Per-cycle model: transmitter busy, scoreboard, requester pops.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        busy_start = 0; busy_end = 0; pop_pend = '0; tx_busy = 1'b0;
      end else begin
        if (tx_din_vld) begin
          busy_start = cyc + bus_d;
          busy_end   = busy_start + bus_l;
        end
        tx_busy = (cyc >= busy_start) && (cyc < busy_end);
        if (tx_din_vld) begin
          vld_cyc.push_back(cyc);
          ntotal++;
          if (exp_q.size() == 0) begin
            $display("FAIL sb_unexpected cyc=%0d got id=%0d data=%h, no issue required",
                     cyc, grant_id, tx_din);
          end else begin
            e  = exp_q.pop_front();
            oh = 4'b0001 << e.id;
            if (tx_din !== e.data || grant_id !== e.id || req_ack !== oh)
              $display("FAIL sb_issue cyc=%0d got id=%0d data=%h ack=%b required id=%0d data=%h ack=%b",
                       cyc, grant_id, tx_din, req_ack, e.id, e.data, oh);
            else npass++;
          end
        end else if (req_ack !== 4'b0000) begin
          ntotal++;
          $display("FAIL ack_without_vld cyc=%0d got ack=%b required 0000", cyc, req_ack);
        end
        if (pkt_abort === 1'b1) abort_cyc.push_back(cyc);
        for (int i = 0; i < NR; i++) if (pop_pend[i]) pop_req(i);
        pop_pend = req_ack;
      end
      apply_reqs();
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "bench timeout");
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step();
  endtask

  task automatic wait_issues(input int n, input int budget, input string tag);
    int k = 0;
    while (vld_cyc.size() < n && k < budget) begin step(); k++; end
    if (vld_cyc.size() < n) begin
      ntotal++;
      $display("FAIL %s_timeout got %0d issues required %0d", tag, vld_cyc.size(), n);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    rq0.delete(); rq1.delete(); rq2.delete(); rq3.delete();
    exp_q.delete(); vld_cyc.delete(); abort_cyc.delete();
    apply_reqs();
    rst = 1'b0;
    step();
  endtask

  task automatic check_zero_outputs(input string tag);
    ntotal++; if (req_ack !== 4'b0) $display("FAIL %s_ack got %b required 0", tag, req_ack); else npass++;
    ntotal++; if (tx_din !== 8'h00) $display("FAIL %s_din got %h required 00", tag, tx_din); else npass++;
    ntotal++; if (tx_din_vld !== 1'b0) $display("FAIL %s_vld got %b required 0", tag, tx_din_vld); else npass++;
    ntotal++; if (grant_id !== 2'd0) $display("FAIL %s_gid got %0d required 0", tag, grant_id); else npass++;
    ntotal++; if (pkt_abort !== 1'b0) $display("FAIL %s_abort got %b required 0", tag, pkt_abort); else npass++;
  endtask

  task automatic test_reset();
    repeat (2) step();
    check_zero_outputs("reset");
    push_req(1, 1'b1, 8'hEE);
    apply_reqs();
    repeat (3) step();
    ntotal++;
    if (tx_din_vld !== 1'b0) $display("FAIL reset_hold got vld=%b required 0", tx_din_vld); else npass++;
  endtask

  task automatic test_single_byte();
    int t;
    do_reset();
    bus_d = 1; bus_l = 4;
    t = cyc;
    push_req(2, 1'b1, 8'h55); push_exp(2, 8'h55); apply_reqs();
    wait_issues(1, 50, "single");
    ntotal++;
    if (vld_cyc.size() < 1 || vld_cyc[0] != t + 1)
      $display("FAIL single_latency got cyc=%0d required %0d", (vld_cyc.size() > 0) ? vld_cyc[0] : -1, t + 1);
    else npass++;
    // Pointer now sits at 3, so 3 beats 0.
    push_req(0, 1'b1, 8'h10); push_req(3, 1'b1, 8'h30);
    push_exp(3, 8'h30); push_exp(0, 8'h10); apply_reqs();
    wait_issues(3, 100, "single_rr");
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int r = 0; r < 2; r++) begin
      push_req(0, 1'b1, 8'(8'h00 + r));
      push_req(1, 1'b1, 8'(8'h10 + r));
      push_req(3, 1'b1, 8'(8'h30 + r));
      push_exp(0, 8'(8'h00 + r));
      push_exp(1, 8'(8'h10 + r));
      push_exp(3, 8'(8'h30 + r));
    end
    apply_reqs();
    wait_issues(6, 200, "round_robin");
  endtask

  task automatic test_packet_lock();
    do_reset();
    push_req(1, 1'b0, 8'hA1); push_req(1, 1'b0, 8'hA2); push_req(1, 1'b1, 8'hA3);
    push_exp(1, 8'hA1); push_exp(1, 8'hA2); push_exp(1, 8'hA3);
    apply_reqs();
    wait_issues(1, 50, "lock_first");
    push_req(0, 1'b1, 8'hB0); push_exp(0, 8'hB0); apply_reqs();
    wait_issues(4, 200, "lock");
  endtask

  task automatic test_watchdog(input bit race);
    int c;
    do_reset();
    bus_d = 1; bus_l = 4;
    push_req(1, 1'b0, 8'hA1); push_exp(1, 8'hA1); apply_reqs();
    wait_issues(1, 50, "wd_first");
    c = (vld_cyc.size() > 0) ? vld_cyc[0] : cyc;
    push_req(0, 1'b1, 8'hB0); push_exp(0, 8'hB0); apply_reqs();
    if (race) begin
      // Idle is re-entered at c+6; the counter hits 15 at c+21.
      wait_until(c + 21);
      push_req(1, 1'b1, 8'hA2); push_exp(1, 8'hA2); apply_reqs();
      wait_issues(3, 200, "wd_race");
    end else begin
      wait_issues(2, 200, "wd");
    end
    ntotal++;
    if (abort_cyc.size() != 1) $display("FAIL wd_abort_count race=%0d got %0d required 1", race, abort_cyc.size());
    else npass++;
    ntotal++;
    if (abort_cyc.size() < 1 || abort_cyc[0] != c + 22)
      $display("FAIL wd_abort_cyc race=%0d got %0d required %0d", race,
               (abort_cyc.size() > 0) ? abort_cyc[0] : -1, c + 22);
    else npass++;
    ntotal++;
    if (vld_cyc.size() < 2 || vld_cyc[1] != c + 23)
      $display("FAIL wd_regrant race=%0d got %0d required %0d", race,
               (vld_cyc.size() > 1) ? vld_cyc[1] : -1, c + 23);
    else npass++;
  endtask

  task automatic test_busy_pacing();
    do_reset();
    bus_d = 2; bus_l = 100;
    push_req(2, 1'b1, 8'hC0); push_req(2, 1'b1, 8'hC1);
    push_exp(2, 8'hC0); push_exp(2, 8'hC1); apply_reqs();
    wait_issues(2, 400, "pace_busy");
    ntotal++;
    if (vld_cyc.size() < 2 || vld_cyc[1] - vld_cyc[0] != 104)
      $display("FAIL pace_busy got spacing %0d required 104",
               (vld_cyc.size() > 1) ? vld_cyc[1] - vld_cyc[0] : -1);
    else npass++;
    wait_until(((vld_cyc.size() > 1) ? vld_cyc[1] : cyc) + 110);
    bus_l = 0;
    push_req(2, 1'b1, 8'hC2); push_req(2, 1'b1, 8'hC3);
    push_exp(2, 8'hC2); push_exp(2, 8'hC3); apply_reqs();
    wait_issues(4, 100, "pace_nobusy");
    ntotal++;
    if (vld_cyc.size() < 4 || vld_cyc[3] - vld_cyc[2] != 5)
      $display("FAIL pace_nobusy got spacing %0d required 5",
               (vld_cyc.size() > 3) ? vld_cyc[3] - vld_cyc[2] : -1);
    else npass++;
  endtask

  task automatic test_reset_mid_packet();
    int c;
    do_reset();
    bus_d = 1; bus_l = 50;
    push_req(3, 1'b0, 8'hD1); push_req(3, 1'b1, 8'hD2);
    push_exp(3, 8'hD1); apply_reqs();
    wait_issues(1, 50, "rst_mid_first");
    c = (vld_cyc.size() > 0) ? vld_cyc[0] : cyc;
    wait_until(c + 10);
    push_req(0, 1'b1, 8'hE0); apply_reqs();
    rst = 1'b1;
    #1;
    check_zero_outputs("rst_mid");
    repeat (2) step();
    push_exp(0, 8'hE0); push_exp(3, 8'hD2);
    rst = 1'b0;
    wait_issues(3, 200, "rst_mid");
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_round_robin();
    test_packet_lock();
    test_watchdog(1'b0);
    test_watchdog(1'b1);
    test_busy_pacing();
    test_reset_mid_packet();
    repeat (5) step();
    ntotal++;
    if (exp_q.size() != 0) $display("FAIL sb_leftover got %0d pending required 0", exp_q.size());
    else npass++;
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin arbiter and sequencer that shares one `uart_tx` byte transmitter between `NUM_REQ` requesters, such as a command echo path, a status reporter and a debug dump.
- Packets are kept atomic: once a requester is granted, it keeps the transmitter until its byte flagged `last` has been handed over.
- The block sits between the requesters and `uart_tx`. It drives the transmitter's byte/valid input and paces itself from the transmitter's busy flag.
- A gap watchdog releases a requester that stalls mid-packet.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_W`, 8: byte width.
- `GAP_MAX`, 16'd50000: maximum idle cycles inside a locked packet before it is aborted.

Ports:
- `clk`  input  1: system clock.
- `rst`  input  1: reset, asynchronous, active-high.
- `req_vld`  input  NUM_REQ: requester i has a byte pending.
- `req_data`  input  NUM_REQ*DATA_W: byte of requester i in bits [i*DATA_W +: DATA_W].
- `req_last`  input  NUM_REQ: the pending byte of requester i ends its packet.
- `req_ack`  output  NUM_REQ: one-cycle pulse; requester i's byte was taken.
- `tx_din`  output  DATA_W: byte to `uart_tx`.
- `tx_din_vld`  output  1: one-cycle start pulse to `uart_tx`.
- `tx_busy`  input  1: high while `uart_tx` is shifting a frame.
- `grant_id`  output  clog2(NUM_REQ): current or last granted requester.
- `pkt_abort`  output  1: one-cycle pulse when the gap watchdog releases a lock.

## Operation
FSM states are IDLE, ISSUE, WAIT_HI and WAIT_LO.

**IDLE**
- Unlocked:
  - Pick the first i with `req_vld[i]`=1, scanning from `rr_ptr` upward and wrapping.
  - If there is a winner, latch `grant_id`=i and `tx_din`=req_data[i], set `locked`=1, and go to ISSUE.
- Locked:
  - Only `req_vld[grant_id]` is considered; all others are ignored.
  - If it is 1, latch the byte and go to ISSUE.
  - If it is 0, increment `gap_cnt`.
  - When `gap_cnt` reaches GAP_MAX-1, pulse `pkt_abort`, clear `locked`, set `rr_ptr`=grant_id+1 (wrapping), clear `gap_cnt`, and stay in IDLE.

**ISSUE**
- Lasts exactly one cycle.
- `tx_din_vld`=1 and `req_ack[grant_id]`=1 in this cycle.
- If the issued byte's `last` was 1 (captured in IDLE), clear `locked` and set `rr_ptr`=grant_id+1, wrapping at NUM_REQ.
- Clear `gap_cnt` and go to WAIT_HI.

**WAIT_HI**
- Wait for `tx_busy`=1, then go to WAIT_LO.
- If `tx_busy` is still 0 after 4 cycles, treat the frame as done and go to IDLE. This protects against a transmitter that never asserts busy.

**WAIT_LO**
- Wait for `tx_busy`=0, then go to IDLE.

**Rules**
- Requesters hold `req_vld`, `req_data` and `req_last` stable until they see `req_ack`.
- A requester may change its inputs in the cycle after `req_ack`.
- Requesters are never resampled before the frame finishes, so a stale `req_vld` is not double-counted.
- `rr_ptr` advances only at packet end or abort, never per byte.
- A single-byte packet has `last`=1 on its first byte.
- `gap_cnt` is 16 bits and saturates at GAP_MAX-1.
- If `req_vld[grant_id]` rises in the same cycle as the watchdog expires, the abort wins and the byte is arbitrated afresh.

**Reset** (async, any state)
- State goes to IDLE.
- `locked`, `rr_ptr` and `gap_cnt` go to 0.
- An in-flight `uart_tx` frame is not cancelled. The FSM resumes in IDLE and may issue while `tx_busy`=1; the system guarantees both blocks share `rst`.

## Timing
- All outputs are registered.
- Reset values: `req_ack`=0, `tx_din`=0, `tx_din_vld`=0, `grant_id`=0, `pkt_abort`=0.
- Latency from `req_vld` sampled in IDLE to `tx_din_vld`/`req_ack`: 1 cycle.
- Minimum spacing between two `tx_din_vld` pulses: 1 + (busy rise delay) + (busy high time) + 1 cycles.
- At most one `req_ack` bit is high in any cycle, and only together with `tx_din_vld`.

## Structure
- A shared package holds the FSM state encoding (IDLE=0, ISSUE=1, WAIT_HI=2, WAIT_LO=3) and the WAIT_HI timeout constant (4).
- One sub-module is natural: `rr_pick`, a combinational round-robin priority picker.
  - Inputs: `NUM_REQ` request vector and start pointer.
  - Outputs: winner index and found flag.
  - Implemented as a double-width vector and a mask.
- Estimated size: about 180 lines of RTL.

## Test plan
- **Single byte:** only req 2 asserts with 8'h55 and `last`=1. Expect `tx_din`=8'h55 and `tx_din_vld`/`req_ack[2]` one cycle later, `grant_id`=2, and `rr_ptr`=3 afterwards.
- **Round-robin:** reqs 0, 1 and 3 all hold single-byte packets continuously. Grant order is 0, 1, 3, 0, 1, 3; no requester is served twice in a row while others wait.
- **Packet lock:** req 1 sends 3 bytes (8'hA1, A2, A3, `last` on A3) while req 0 is pending. Expect A1, A2, A3 to go out contiguously before any byte of req 0.
- **Watchdog:**
  - With GAP_MAX=16, req 1 sends A1 (`last`=0) then drops `req_vld`. Expect `pkt_abort` exactly 16 cycles after the return to IDLE, then req 0 granted.
  - Repeat with `req_vld[1]` rising on the expiry cycle. The abort still fires.
- **Busy pacing:** the transmitter model holds `tx_busy` for 100 cycles starting 2 cycles after `tx_din_vld`. Expect no second `tx_din_vld` until 1 cycle after `tx_busy` falls. With busy never asserted, expect the next issue 5 cycles after ISSUE.
- **Reset mid-packet:** assert `rst` in WAIT_LO with req 3 locked. All outputs are 0 immediately, and after release req 0 wins the first arbitration.
